arbiter_4rr_dec: RTL and testbench
==================================

# arbiter_4rr_dec

Four-requester round-robin arbiter that shares one 2-to-4 decoded resource (one-hot select lines plus enable) between four masters. It picks a winner, drives the winner's index and enable, and decodes them to a one-hot grant vector. It holds the grant while the owner keeps requesting, up to a bounded tenure. Every change of owner is separated by one dead cycle. It sits in front of any decoder-selected shared resource, e.g. a 4-way bus select or a display/peripheral select.

## Interface
- HOLD_MAX, default 8: maximum consecutive cycles one owner may hold the grant; legal range 2..255.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines, bit i = requester i; level-sensitive, sampled on rising edge.
- gnt  output  4  one-hot grant, registered; equals decode of {gnt_vld, gnt_idx}, all zero when gnt_vld = 0.
- gnt_idx  output  2  index of current owner; holds its last value when gnt_vld = 0.
- gnt_vld  output  1  grant enable; high while a grant is active.
- tmo  output  1  one-cycle pulse on the cycle the grant drops because of HOLD_MAX expiry.

## Operation
- State machine states: IDLE, GRANT, GAP. Internal registers:
  - ptr[1:0]: highest-priority index.
  - hold_cnt, width $clog2(HOLD_MAX+1): saturating.
- Arbitration is combinational on the sampled req. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first set bit wins.
- IDLE:
  - req == 0: stay in IDLE, outputs idle.
  - Any req bit set: load gnt_idx = winner, gnt_vld = 1, gnt = one-hot(winner), hold_cnt = 1, go to GRANT.
- GRANT:
  - Normal release: req[gnt_idx] == 0 at the edge. Drop the grant, ptr = gnt_idx+1 mod 4, go to GAP.
  - Forced release: req[gnt_idx] == 1 and hold_cnt == HOLD_MAX. Drop the grant, ptr = gnt_idx+1 mod 4, tmo = 1 for that cycle, go to GAP.
  - Otherwise: hold the grant and increment hold_cnt.
- GAP: gnt = 0 and gnt_vld = 0 for exactly one cycle. At the next edge, arbitrate with the updated ptr:
  - Winner exists: go to GRANT, loading the winner as in IDLE.
  - No winner: go to IDLE.
- Other requesters' req changes during GRANT have no effect until the next arbitration.
- A forcibly released owner that is the only requester is re-granted after the one-cycle GAP.
- Illegal or unreachable state encoding: go to IDLE with all outputs idle.

## Timing
- Reset values, applied asynchronously while rst_n = 0:
  - gnt = 4'b0000, gnt_idx = 2'b00, gnt_vld = 0, tmo = 0.
  - ptr = 0, hold_cnt = 0, state IDLE.
- Reset release takes effect at the first rising edge with rst_n = 1.
- Reset asserted mid-grant clears gnt immediately, without waiting for a clock. After reset, arbitration restarts at ptr = 0.
- Latency: req sampled high at edge N in IDLE gives gnt high after edge N, visible during cycle N+1.
- Release latency:
  - Normal: owner's req sampled low at edge N gives gnt low after edge N.
  - Tenure: gnt is high for at most HOLD_MAX consecutive cycles per owner.
- tmo is high only in the first GAP cycle, and only after a forced release.
- Handover: gnt is never high for two owners in consecutive cycles. There is a minimum of one all-zero cycle between any two grants, including a re-grant to the same owner.
- Worst-case wait for a continuously requesting master: 3 × (HOLD_MAX + 1) cycles after losing arbitration.
- Outputs are registered and glitch-free. gnt, gnt_idx, gnt_vld and tmo all change only on clock edges or on reset assertion.

## Test plan
- Reset: hold rst_n = 0 with req = 4'b1111 → gnt = 0, gnt_vld = 0, tmo = 0. Release reset → gnt = 4'b0001 one cycle later.
- Single requester: req = 4'b0100 for 3 cycles then 0 → gnt = 4'b0100, gnt_idx = 2, for 3 cycles. Then gnt = 0 and state returns to IDLE. ptr = 3, so the next simultaneous req = 4'b1111 grants index 3.
- Round-robin: req = 4'b1111 held constant, HOLD_MAX = 8 → grants in order idx 0,1,2,3,0. Each grant lasts 8 cycles with one zero cycle between grants, and tmo pulses once per handover.
- Sole hog: req = 4'b0010 held, HOLD_MAX = 8 → the pattern 8 cycles gnt = 4'b0010, then 1 cycle of 0 with tmo = 1, repeats indefinitely.
- Simultaneous events: owner idx 1 drops req on the same edge that idx 3 and idx 0 raise req → one GAP cycle, then idx 3 is granted (ptr = 2, search order 2,3,0,1). tmo stays 0.
- Mid-grant reset: assert rst_n = 0 asynchronously halfway through a grant → gnt clears before the next edge. After release with req = 4'b1000 → idx 3 is granted one cycle later.

Source files
------------

// File: rtl/arbiter_4rr_dec.sv
// Four-way round-robin arbiter with bounded tenure and a dead cycle
// between owners; drives a registered one-hot grant plus index/enable.
module arbiter_4rr_dec #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       tmo
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          tmo_q, tmo_d;
  logic [3:0]    gnt_q, gnt_d;

  logic          win_vld;
  logic [1:0]    win_idx;
  logic [1:0]    cand;
  logic          own_req;
  logic          at_max;

  // Walk from lowest to highest priority so the ptr slot wins last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign own_req = req[idx_q];
  assign at_max  = (hold_q == HW'(HOLD_MAX));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        vld_d = 1'b0;
        if (win_vld) begin
          state_d = GRANT;
          idx_d   = win_idx;
          vld_d   = 1'b1;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        unique case (1'b1)
          !own_req: begin
            state_d = GAP;
            vld_d   = 1'b0;
            ptr_d   = idx_q + 2'd1;
          end
          own_req && at_max: begin
            state_d = GAP;
            vld_d   = 1'b0;
            ptr_d   = idx_q + 2'd1;
            tmo_d   = 1'b1;
          end
          default: begin
            if (hold_q != {HW{1'b1}}) begin
              hold_d = hold_q + HW'(1);
            end
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  assign gnt_d = vld_d ? (4'b0001 << idx_d) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_arbiter_4rr_dec.sv
// Bench for arbiter_4rr_dec: owner/tenure model checked every cycle,
// plus hand-derived grant sequences for the main scenarios.
module tb_arbiter_4rr_dec;

  localparam int HM = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  arbiter_4rr_dec #(.HOLD_MAX(HM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: who owns the resource and for how long.
  int m_owner = -1;
  int m_ten   = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_tmo   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ten   = 0;
      m_ptr   = 0;
      m_last  = 0;
      m_tmo   = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
        end else if (m_ten == HM) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
          m_tmo   = 1'b1;
        end else begin
          m_ten++;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_ten   = 1;
            m_last  = m_owner;
          end
        end
      end
    end
  end

  function automatic logic [3:0] m_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_gnt", 32'(gnt), 32'(m_gnt()));
      chk("m_idx", 32'(gnt_idx), 32'(m_last));
      chk("m_vld", 32'(gnt_vld), 32'(m_owner >= 0));
      chk("m_tmo", 32'(tmo), 32'(m_tmo));
    end
  end

  initial begin
    logic [3:0] e;
    rst_n = 1'b1;
    req   = 4'b1111;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_vld", 32'(gnt_vld), 32'h0);
    chk("rst_tmo", 32'(tmo), 32'h0);
    rst_n = 1'b1;

    // All four requesting: 8-cycle tenures, gap with tmo between.
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      e = (k % 9 == 0) ? 4'b0000 : 4'(4'b0001 << (((k - 1) / 9) % 4));
      chk("rr_gnt", 32'(gnt), 32'(e));
      chk("rr_tmo", 32'(tmo), 32'(k % 9 == 0));
      if (k == 1) chk("model_pin", 32'(m_gnt()), 32'h1);
    end

    req = 4'b0000;
    @(negedge clk);
    chk("drop_gap", 32'(gnt), 32'h0);
    chk("drop_tmo", 32'(tmo), 32'h0);
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'h0);

    // Sole hog on index 1.
    req = 4'b0010;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      e = (j % 9 == 0) ? 4'b0000 : 4'b0010;
      chk("hog_gnt", 32'(gnt), 32'(e));
      chk("hog_tmo", 32'(tmo), 32'(j % 9 == 0));
    end
    req = 4'b0000;
    @(negedge clk);
    chk("hog_idle", 32'(gnt), 32'h0);
    chk("hog_idle_tmo", 32'(tmo), 32'h0);

    // Single requester index 2 for three cycles.
    req = 4'b0100;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_idx", 32'(gnt_idx), 32'h2);
    end
    req = 4'b0000;
    @(negedge clk);
    chk("single_rel", 32'(gnt), 32'h0);
    chk("single_idxh", 32'(gnt_idx), 32'h2);
    chk("single_vld", 32'(gnt_vld), 32'h0);
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    chk("ptr3_gnt", 32'(gnt), 32'h8);
    chk("ptr3_idx", 32'(gnt_idx), 32'h3);

    // Owner 1 drops while 3 and 0 raise: ptr=2 picks 3.
    req = 4'b0010;
    @(negedge clk);
    chk("sim_gap0", 32'(gnt), 32'h0);
    @(negedge clk);
    chk("sim_own1", 32'(gnt), 32'h2);
    req = 4'b1001;
    @(negedge clk);
    chk("sim_gap", 32'(gnt), 32'h0);
    chk("sim_tmo", 32'(tmo), 32'h0);
    @(negedge clk);
    chk("sim_win3", 32'(gnt), 32'h8);
    chk("sim_tmo2", 32'(tmo), 32'h0);

    // Asynchronous reset in the middle of a grant.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_vld", 32'(gnt_vld), 32'h0);
    chk("async_idx", 32'(gnt_idx), 32'h0);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h8);
    chk("post_rst_idx", 32'(gnt_idx), 32'h3);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
